// File: rtl/mux_nx1_stream.sv
// N-to-1 valid/ready stream multiplexer with a one-entry output register.
// Selection is either an external channel select (MODE=0) or round-robin
// over the valid channels (MODE=1).
module mux_nx1_stream #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 1,
  parameter int unsigned MODE = 0,
  localparam int unsigned SW  = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  input  logic            out_ready,
  output logic [SW-1:0]   out_chan
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] chan_q, chan_d;

  logic          loadable;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic [SW:0]   cand;
  logic          in_xfer;
  logic          out_xfer;

  // Grant: external select, or first valid channel searching from ptr upward with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (MODE == 0) begin
      grant_found = (32'(sel) < N);
      grant_idx   = sel;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        cand = {1'b0, ptr_q} + (SW+1)'(i);
        if (cand >= (SW+1)'(N)) begin
          cand = cand - (SW+1)'(N);
        end
        if (!grant_found && in_valid[cand[SW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[SW-1:0];
        end
      end
    end
  end

  // Data slice of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (grant_idx == SW'(k)) begin
        grant_data = in_data[k*W +: W];
      end
    end
  end

  // Handshake: the register accepts a word when empty or when draining this cycle.
  always_comb begin
    loadable = !rst && ((state_q == ST_EMPTY) || out_ready);
    in_ready = '0;
    if (loadable && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
    in_xfer  = |(in_valid & in_ready);
    out_xfer = (state_q == ST_FULL) && out_ready;
  end

  // Next state: load on input transfer (also covers pass-through), empty on drain only.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    if (in_xfer) begin
      state_d = ST_FULL;
      data_d  = grant_data;
      chan_d  = grant_idx;
      if (MODE != 0) begin
        ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      end
    end else if (out_xfer) begin
      state_d = ST_EMPTY;
    end
  end

  // State and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule
